// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with a per-register busy scoreboard.
//
// Register 0 reads as zero, ignores writes, and is never busy. Reads are
// combinational. Writes and busy updates happen on the rising clock edge.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports. Without it, same-cycle reads return the stored value.
//
// Parameters:
//   WIDTH      data bits per register
//   ADDR_BITS  address width; depth = 2**ADDR_BITS
//   NREAD      number of asynchronous read ports
//
// Ports:
//   Clk              rising-edge clock
//   Reset            synchronous, active-high reset; clears data and busy bits
//   ReadRegister     read addresses; port k at [k*ADDR_BITS +: ADDR_BITS]
//   ReadData         read data; port k at [k*WIDTH +: WIDTH]
//   ReadBusy         busy bit of the register each port addresses
//   WriteRegister    write address
//   WriteData        write data
//   RegWrite         write enable; also clears busy[WriteRegister]
//   ReserveRegister  register to mark pending
//   Reserve          reservation enable
//   AnyBusy          OR of all busy bits (registered state only)
module regfile_param #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned NREAD     = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NREAD*ADDR_BITS-1:0] ReadRegister,
  output logic [NREAD*WIDTH-1:0]     ReadData,
  output logic [NREAD-1:0]           ReadBusy,
  input  logic [ADDR_BITS-1:0]       WriteRegister,
  input  logic [WIDTH-1:0]           WriteData,
  input  logic                       RegWrite,
  input  logic [ADDR_BITS-1:0]       ReserveRegister,
  input  logic                       Reserve,
  output logic                       AnyBusy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Register 0 has no storage; its reads are forced to zero below.
  logic [WIDTH-1:0] r_mem [1:DEPTH-1];
  logic [DEPTH-1:0] r_busy;

  logic w_wr_en;
  logic w_rsv_en;

  assign w_wr_en  = RegWrite && (WriteRegister != '0);
  assign w_rsv_en = Reserve && (ReserveRegister != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[WriteRegister] <= WriteData;
      end
      if (RegWrite) begin
        r_busy[WriteRegister] <= 1'b0;
      end
      // Placed after the clear so a same-cycle reservation (new producer) wins.
      if (w_rsv_en) begin
        r_busy[ReserveRegister] <= 1'b1;
      end
      r_busy[0] <= 1'b0;
    end
  end

  assign AnyBusy = |r_busy;

  for (genvar k = 0; k < NREAD; k++) begin : gen_rd
    logic [ADDR_BITS-1:0] w_raddr;
    logic [WIDTH-1:0]     w_rdata;
    logic                 w_rbusy;

    assign w_raddr = ReadRegister[k*ADDR_BITS +: ADDR_BITS];

    always_comb begin
      w_rdata = '0;
      w_rbusy = r_busy[w_raddr];
      if (w_raddr != '0) begin
        w_rdata = r_mem[w_raddr];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight write; busy stays set only if re-reserved now.
      if (w_wr_en && (w_raddr == WriteRegister)) begin
        w_rdata = WriteData;
        w_rbusy = w_rsv_en && (ReserveRegister == w_raddr);
      end
`endif
    end

    assign ReadData[k*WIDTH +: WIDTH] = w_rdata;
    assign ReadBusy[k]                = w_rbusy;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: table-driven self-checking bench for regfile_param with
// three read ports. Each vector's expected outputs are pushed to a scoreboard
// when the vector is driven and popped when outputs are sampled mid-cycle.
module tb_regfile_param;

  localparam int W  = 32;
  localparam int AB = 5;
  localparam int NR = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NR*AB-1:0] ReadRegister;
  logic [NR*W-1:0]  ReadData;
  logic [NR-1:0]    ReadBusy;
  logic [AB-1:0]    WriteRegister;
  logic [W-1:0]     WriteData;
  logic             RegWrite;
  logic [AB-1:0]    ReserveRegister;
  logic             Reserve;
  logic             AnyBusy;

  always #5 Clk = ~Clk;

  regfile_param #(
    .WIDTH    (W),
    .ADDR_BITS(AB),
    .NREAD    (NR)
  ) u_dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ReadRegister   (ReadRegister),
    .ReadData       (ReadData),
    .ReadBusy       (ReadBusy),
    .WriteRegister  (WriteRegister),
    .WriteData      (WriteData),
    .RegWrite       (RegWrite),
    .ReserveRegister(ReserveRegister),
    .Reserve        (Reserve),
    .AnyBusy        (AnyBusy)
  );

  typedef struct {
    bit          chk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  rr;
    logic [14:0] ra;
    logic [95:0] d;
    logic [2:0]  b;
    logic        any;
  } vec_t;

  typedef struct {
    logic [95:0] d;
    logic [2:0]  b;
    logic        any;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // b: bit k is the expected ReadBusy of port k.
  function automatic vec_t mk(bit chk, logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic rv, logic [4:0] rr, logic [4:0] a0, logic [4:0] a1,
                              logic [4:0] a2, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [2:0] b, logic any);
    vec_t v;
    v.chk = chk; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.rr = rr;
    v.ra  = {a2, a1, a0};
    v.d   = {d2, d1, d0};
    v.b   = b;
    v.any = any;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset           = v.rst;
    RegWrite        = v.we;
    WriteRegister   = v.wa;
    WriteData       = v.wd;
    Reserve         = v.rv;
    ReserveRegister = v.rr;
    ReadRegister    = v.ra;
    if (v.chk) begin
      e.d = v.d; e.b = v.b; e.any = v.any; e.idx = idx;
      sb.push_back(e);
    end
    @(negedge Clk);
    if (v.chk) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL vec%0d scoreboard: got empty queue, expected an entry", idx);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < NR; k++) begin
          n_cmp++;
          if (ReadData[k*W +: W] !== e.d[k*32 +: 32]) begin
            n_bad++;
            $display("FAIL vec%0d port%0d data: got %h expected %h", e.idx, k,
                     ReadData[k*W +: W], e.d[k*32 +: 32]);
          end
          n_cmp++;
          if (ReadBusy[k] !== e.b[k]) begin
            n_bad++;
            $display("FAIL vec%0d port%0d busy: got %b expected %b", e.idx, k, ReadBusy[k],
                     e.b[k]);
          end
        end
        n_cmp++;
        if (AnyBusy !== e.any) begin
          n_bad++;
          $display("FAIL vec%0d anybusy: got %b expected %b", e.idx, AnyBusy, e.any);
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    Reserve = 1'b0; ReserveRegister = '0; ReadRegister = '0;

    // Fields: chk rst we wa wd rv rr | a0 a1 a2 | d0 d1 d2 | busy any
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 5, 17, 30, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 31, 32'hCAFEF00D, 0, 0, 0, 5, 0, 0, 32'h12345678, 0, 3'b000,
                     0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 5, 31, 0, 32'h12345678, 32'hCAFEF00D, 0, 3'b000,
                     0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 5, 5, 5, 32'h12345678, 32'h12345678, 32'h12345678,
                     3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 7, 32'h42, 0, 0, 7, 5, 0, BYP ? 32'h42 : 32'h0, 32'h12345678,
                     0, BYP ? 3'b000 : 3'b001, 1));
    tbl.push_back(mk(1, 0, 1, 9, 32'hAAAA5555, 1, 9, 7, 9, 7, 32'h42,
                     BYP ? 32'hAAAA5555 : 32'h0, 32'h42, BYP ? 3'b010 : 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 9, 9, 0, 32'hAAAA5555, 32'hAAAA5555, 0, 3'b011, 1));
    tbl.push_back(mk(1, 0, 1, 3, 32'h1, 0, 0, 0, 9, 0, 0, 32'hAAAA5555, 0, 3'b010, 1));
    tbl.push_back(mk(1, 0, 1, 3, 32'h0BADC0DE, 0, 0, 3, 3, 9, BYP ? 32'h0BADC0DE : 32'h1,
                     BYP ? 32'h0BADC0DE : 32'h1, 32'hAAAA5555, 3'b100, 1));
    tbl.push_back(mk(1, 0, 1, 9, 32'h5, 0, 0, 3, 3, 3, 32'h0BADC0DE, 32'h0BADC0DE,
                     32'h0BADC0DE, 3'b000, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 9, 0, 0, 32'h5, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 1, 2, 32'h77, 1, 6, 4, 6, 1, 0, 0, 0, 3'b001, 1));
    tbl.push_back(mk(1, 1, 1, 2, 32'h99, 0, 0, 5, 4, 6, 32'h12345678, 0, 0, 3'b110, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 4, 6, 0, 0, 0, 3'b000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 5, 31, 9, 0, 0, 0, 3'b000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], i);
    end

    // Double reservation: one write still clears the busy bit.
    run(mk(1, 0, 0, 0, 0, 1, 10, 10, 0, 0, 0, 0, 0, 3'b000, 0), 100);
    run(mk(1, 0, 0, 0, 0, 1, 10, 10, 0, 0, 0, 0, 0, 3'b001, 1), 101);
    run(mk(1, 0, 1, 10, 32'hABC, 0, 0, 10, 0, 0, BYP ? 32'hABC : 32'h0, 0, 0,
           BYP ? 3'b000 : 3'b001, 1), 102);
    run(mk(1, 0, 0, 0, 0, 0, 0, 10, 10, 10, 32'hABC, 32'hABC, 32'hABC, 3'b000, 0), 103);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
